// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: single-instruction valid/ready intake, dcache
// request/response handshake, byte-lane store/load alignment and tohost CSR.
module mem_wb_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] CSR_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst_in,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   alu_out,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   rs1_to_csr,
   output logic              dcache_req_valid,
   input  logic              dcache_req_ready,
   output logic [XLEN-1:0]   dcache_addr,
   output logic [XLEN/8-1:0] dcache_we,
   output logic [XLEN-1:0]   dcache_din,
   input  logic              dcache_resp_valid,
   input  logic [XLEN-1:0]   dcache_dout,
   output logic              wb_valid,
   output logic [XLEN-1:0]   wb_data,
   output logic [4:0]        rd,
   output logic [XLEN-1:0]   csr_out,
   output logic              misalign
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state, state_next;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [1:0]      size;
   logic [OW-1:0]   off, amask;
   logic            is_load, is_store, misaligned;
   logic [NB-1:0]   base_we, st_we;
   logic [XLEN-1:0] st_din;
   logic            wr_rd, csr_we;
   logic [XLEN-1:0] nm_data, csr_val;

   logic [OW-1:0]   l_off;
   logic [2:0]      l_f3;
   logic [4:0]      l_rd;
   logic            l_store;
   logic [XLEN-1:0] shifted, ld_data;

   logic accept, issue, finish;

   assign in_ready = (state == IDLE);

   // Decode of the instruction currently offered on the input side
   always_comb begin
      opcode   = inst_in[6:0];
      funct3   = inst_in[14:12];
      size     = funct3[1:0];
      off      = alu_out[OW-1:0];
      is_load  = (opcode == OPC_LOAD) && (funct3 != 3'b111) && (size != 2'd3 || XLEN == 64);
      is_store = (opcode == OPC_STORE) && !funct3[2] && (size != 2'd3 || XLEN == 64);
      case (size)
         2'd0: begin
            amask   = '0;
            base_we = NB'(1);
            st_din  = {NB{store_data[7:0]}};
         end
         2'd1: begin
            amask   = OW'(1);
            base_we = NB'(3);
            st_din  = {(NB/2){store_data[15:0]}};
         end
         2'd2: begin
            amask   = OW'(3);
            base_we = NB'(15);
            st_din  = {(NB/4){store_data[31:0]}};
         end
         default: begin
            amask   = '1;
            base_we = '1;
            st_din  = store_data;
         end
      endcase
      misaligned = |(off & amask);
      st_we      = base_we << off;

      wr_rd   = 1'b0;
      nm_data = alu_out;
      csr_we  = 1'b0;
      csr_val = rs1_to_csr;
      case (opcode)
         OPC_JAL, OPC_JALR: begin
            wr_rd   = 1'b1;
            nm_data = pc_in + XLEN'(4);
         end
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: wr_rd = 1'b1;
         OPC_SYSTEM: begin
            if (inst_in[31:20] == 12'h51E) begin
               if (funct3 == 3'b001) begin
                  csr_we = 1'b1;
               end else if (funct3 == 3'b101) begin
                  csr_we  = 1'b1;
                  csr_val = XLEN'(inst_in[19:15]);
               end
            end
         end
         default: ;
      endcase
   end

   // Load extraction uses the offset/funct3 latched at accept time
   always_comb begin
      shifted = dcache_dout >> {l_off, 3'b000};
      case (l_f3)
         3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
         3'b100:  ld_data = XLEN'(shifted[7:0]);
         3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
         3'b101:  ld_data = XLEN'(shifted[15:0]);
         3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
         3'b110:  ld_data = XLEN'(shifted[31:0]);
         default: ld_data = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               issue      = (is_load || is_store) && !misaligned;
               state_next = issue ? REQ : DONE;
            end
         end
         REQ: begin
            if (dcache_req_ready) begin
               if (l_store || dcache_resp_valid) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            if (dcache_resp_valid) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Non-memory and misaligned instructions retire straight from accept, so
   // their writeback registers load on the accept edge and show in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         dcache_req_valid <= 1'b0;
         dcache_addr      <= '0;
         dcache_we        <= '0;
         dcache_din       <= '0;
         wb_valid         <= 1'b0;
         wb_data          <= '0;
         rd               <= '0;
         misalign         <= 1'b0;
         csr_out          <= CSR_RESET;
         l_off            <= '0;
         l_f3             <= '0;
         l_rd             <= '0;
         l_store          <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         misalign <= 1'b0;
         if (accept) begin
            l_off   <= off;
            l_f3    <= funct3;
            l_rd    <= inst_in[11:7];
            l_store <= is_store;
            if (issue) begin
               dcache_req_valid <= 1'b1;
               dcache_addr      <= alu_out & ~XLEN'(NB - 1);
               dcache_we        <= is_store ? st_we : '0;
               dcache_din       <= is_store ? st_din : '0;
            end else begin
               wb_valid <= 1'b1;
               misalign <= is_load || is_store;
               rd       <= wr_rd ? inst_in[11:7] : '0;
               wb_data  <= wr_rd ? nm_data : '0;
               if (csr_we) csr_out <= csr_val;
            end
         end
         if (state == REQ && dcache_req_ready) dcache_req_valid <= 1'b0;
         if (finish) begin
            wb_valid <= 1'b1;
            rd       <= l_store ? '0 : l_rd;
            wb_data  <= l_store ? '0 : ld_data;
         end
      end
   end
endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed self-checking bench for mem_wb_unit (XLEN=32).
module tb_mem_wb_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inst_in, pc_in, alu_out, store_data, rs1_to_csr;
   logic        dcache_req_valid, dcache_req_ready;
   logic [31:0] dcache_addr, dcache_din, dcache_dout, wb_data, csr_out;
   logic [3:0]  dcache_we;
   logic        dcache_resp_valid, wb_valid, misalign;
   logic [4:0]  rd;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic        r_saw_req, r_wb, r_mis, r_early;
   logic [31:0] r_addr, r_din, r_data;
   logic [3:0]  r_we;
   logic [4:0]  r_rd;

   always #5 clk = ~clk;

   mem_wb_unit #(.XLEN(32), .CSR_RESET(32'h0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .inst_in(inst_in), .pc_in(pc_in), .alu_out(alu_out), .store_data(store_data),
      .rs1_to_csr(rs1_to_csr), .dcache_req_valid(dcache_req_valid),
      .dcache_req_ready(dcache_req_ready), .dcache_addr(dcache_addr), .dcache_we(dcache_we),
      .dcache_din(dcache_din), .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout),
      .wb_valid(wb_valid), .wb_data(wb_data), .rd(rd), .csr_out(csr_out), .misalign(misalign)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one instruction from a negedge; the writeback outputs are sampled
   // in the cycle where wb_valid is expected for the given dcache delays.
   task automatic run_mem(input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] dout,
                          input int rdy_dly, input int resp_dly);
      r_early = 1'b0; r_saw_req = 1'b0; r_addr = '0; r_we = '0; r_din = '0;
      inst_in = inst; alu_out = addr; store_data = sdata; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      if (dcache_req_valid) begin
         r_saw_req = 1'b1; r_addr = dcache_addr; r_we = dcache_we; r_din = dcache_din;
         for (int i = 0; i < rdy_dly; i++) begin
            @(posedge clk); @(negedge clk);
            if (wb_valid || !dcache_req_valid || dcache_addr !== r_addr || dcache_we !== r_we)
               r_early = 1'b1;
         end
         dcache_req_ready = 1'b1;
         if (r_we == 4'h0 && resp_dly == 0) begin
            dcache_resp_valid = 1'b1; dcache_dout = dout;
         end
         @(posedge clk); @(negedge clk);
         dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_dout = '0;
         if (r_we == 4'h0 && resp_dly > 0) begin
            for (int i = 1; i < resp_dly; i++) begin
               if (wb_valid || dcache_req_valid) r_early = 1'b1;
               @(posedge clk); @(negedge clk);
            end
            if (wb_valid) r_early = 1'b1;
            dcache_resp_valid = 1'b1; dcache_dout = dout;
            @(posedge clk); @(negedge clk);
            dcache_resp_valid = 1'b0; dcache_dout = '0;
         end
      end
      r_wb = wb_valid; r_data = wb_data; r_rd = rd; r_mis = misalign;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if ({dcache_req_valid, wb_valid, misalign} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {dcache_req_valid, wb_valid, misalign}); else pass_cnt++;
      total_cnt++; if ({dcache_addr, dcache_din, dcache_we} !== 68'h0) $display("FAIL reset_dcache: got %h/%h/%h want 0", dcache_addr, dcache_din, dcache_we); else pass_cnt++;
      total_cnt++; if ({wb_data, rd} !== 37'h0) $display("FAIL reset_wb: got %h/%0d want 0", wb_data, rd); else pass_cnt++;
      total_cnt++; if (csr_out !== 32'h0) $display("FAIL reset_csr: got %h want 0", csr_out); else pass_cnt++;
   endtask

   task automatic test_alu_jump();
      run_mem(32'h000002B3, 32'h00001234, '0, '0, 0, 0);   // ADD x5
      total_cnt++; if ({r_saw_req, r_wb, r_mis} !== 3'b010) $display("FAIL add_flags: got %b want 010", {r_saw_req, r_wb, r_mis}); else pass_cnt++;
      total_cnt++; if (r_data !== 32'h1234 || r_rd !== 5'd5) $display("FAIL add_wb: got %h/%0d want 1234/5", r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL add_pulse: got wb=%b rdy=%b want 0/1", wb_valid, in_ready); else pass_cnt++;
      pc_in = 32'h100;
      run_mem(32'h000000EF, 32'hFFFF0000, '0, '0, 0, 0);   // JAL x1
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'h104 || r_rd !== 5'd1) $display("FAIL jal_wb: got %b/%h/%0d want 1/104/1", r_wb, r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      pc_in = 32'h200;
      run_mem(32'h00000167, 32'h0, '0, '0, 0, 0);          // JALR x2
      total_cnt++; if (r_data !== 32'h204 || r_rd !== 5'd2) $display("FAIL jalr_wb: got %h/%0d want 204/2", r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00000537, 32'hABCDE000, '0, '0, 0, 0);   // LUI x10
      total_cnt++; if (r_data !== 32'hABCDE000 || r_rd !== 5'd10) $display("FAIL lui_wb: got %h/%0d want abcde000/10", r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00000FE3, 32'h55, '0, '0, 0, 0);         // BRANCH, rd field nonzero
      total_cnt++; if (r_wb !== 1'b1 || r_rd !== 5'd0) $display("FAIL branch_retire: got wb=%b rd=%0d want 1/0", r_wb, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h000001FF, 32'h55, '0, '0, 0, 0);         // unknown opcode
      total_cnt++; if (r_wb !== 1'b1 || r_rd !== 5'd0 || r_mis !== 1'b0) $display("FAIL unknown_retire: got wb=%b rd=%0d mis=%b want 1/0/0", r_wb, r_rd, r_mis); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_load();
      run_mem(32'h00000303, 32'h00001003, '0, 32'h80FFFF00, 2, 3);   // LB x6
      total_cnt++; if (r_saw_req !== 1'b1 || r_addr !== 32'h1000 || r_we !== 4'h0) $display("FAIL lb_req: got %b/%h/%h want 1/1000/0", r_saw_req, r_addr, r_we); else pass_cnt++;
      total_cnt++; if (r_early !== 1'b0) $display("FAIL lb_wait: got early=%b want 0", r_early); else pass_cnt++;
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'hFFFFFF80 || r_rd !== 5'd6) $display("FAIL lb_wb: got %b/%h/%0d want 1/ffffff80/6", r_wb, r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00004303, 32'h00001003, '0, 32'h80FFFF00, 0, 0);   // LBU, resp with ready
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'h00000080) $display("FAIL lbu_wb: got %b/%h want 1/00000080", r_wb, r_data); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00001383, 32'h00001002, '0, 32'h80FFFF00, 1, 1);   // LH x7
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'hFFFF80FF || r_rd !== 5'd7) $display("FAIL lh_wb: got %b/%h/%0d want 1/ffff80ff/7", r_wb, r_data, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00005383, 32'h00001000, '0, 32'h80FFFF00, 0, 2);   // LHU
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'h0000FF00) $display("FAIL lhu_wb: got %b/%h want 1/0000ff00", r_wb, r_data); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h00002403, 32'h00001000, '0, 32'h80FFFF00, 0, 1);   // LW x8
      total_cnt++; if (r_wb !== 1'b1 || r_data !== 32'h80FFFF00 || r_rd !== 5'd8) $display("FAIL lw_wb: got %b/%h/%0d want 1/80ffff00/8", r_wb, r_data, r_rd); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_store();
      run_mem(32'h000010A3, 32'h00002002, 32'hABCD1234, '0, 1, 0);   // SH
      total_cnt++; if (r_addr !== 32'h2000 || r_we !== 4'b1100 || r_din !== 32'h12341234) $display("FAIL sh_req: got %h/%b/%h want 2000/1100/12341234", r_addr, r_we, r_din); else pass_cnt++;
      total_cnt++; if (r_wb !== 1'b1 || r_rd !== 5'd0 || r_early !== 1'b0) $display("FAIL sh_wb: got %b/%0d early=%b want 1/0/0", r_wb, r_rd, r_early); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h000000A3, 32'h00002001, 32'h0000005A, '0, 0, 0);   // SB
      total_cnt++; if (r_we !== 4'b0010 || r_din !== 32'h5A5A5A5A || r_wb !== 1'b1) $display("FAIL sb_req: got %b/%h/%b want 0010/5a5a5a5a/1", r_we, r_din, r_wb); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h000020A3, 32'h00002004, 32'hCAFEF00D, '0, 0, 0);   // SW
      total_cnt++; if (r_addr !== 32'h2004 || r_we !== 4'hF || r_din !== 32'hCAFEF00D) $display("FAIL sw_req: got %h/%h/%h want 2004/f/cafef00d", r_addr, r_we, r_din); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_misalign();
      run_mem(32'h00002403, 32'h00002001, '0, '0, 0, 0);   // LW misaligned
      total_cnt++; if ({r_saw_req, r_wb, r_mis} !== 3'b011 || r_rd !== 5'd0) $display("FAIL lw_misalign: got req/wb/mis=%b rd=%0d want 011/0", {r_saw_req, r_wb, r_mis}, r_rd); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (misalign !== 1'b0 || dcache_req_valid !== 1'b0) $display("FAIL misalign_pulse: got mis=%b req=%b want 0/0", misalign, dcache_req_valid); else pass_cnt++;
      run_mem(32'h000010A3, 32'h00002003, 32'h1111, '0, 0, 0);   // SH misaligned
      total_cnt++; if ({r_saw_req, r_wb, r_mis} !== 3'b011) $display("FAIL sh_misalign: got %b want 011", {r_saw_req, r_wb, r_mis}); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_csr();
      rs1_to_csr = 32'hDEADBEEF;
      run_mem(32'h51E09073, 32'h0, '0, '0, 0, 0);          // csrw tohost
      total_cnt++; if (r_wb !== 1'b1 || csr_out !== 32'hDEADBEEF || r_rd !== 5'd0) $display("FAIL csrw: got wb=%b csr=%h rd=%0d want 1/deadbeef/0", r_wb, csr_out, r_rd); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h51E2D073, 32'h0, '0, '0, 0, 0);          // csrwi 5
      total_cnt++; if (csr_out !== 32'h5) $display("FAIL csrwi: got %h want 5", csr_out); else pass_cnt++;
      @(negedge clk);
      run_mem(32'h30009073, 32'h0, '0, '0, 0, 0);          // csrw to another CSR
      total_cnt++; if (csr_out !== 32'h5) $display("FAIL csr_other: got %h want 5", csr_out); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      inst_in = 32'h000001B3; alu_out = 32'h11; in_valid = 1'b1;   // ADD x3, held valid
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", in_ready); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      alu_out = 32'h22;
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h11 || in_ready !== 1'b0) $display("FAIL b2b_first: got %b/%h rdy=%b want 1/11/0", wb_valid, wb_data, in_ready); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_gap: got wb=%b rdy=%b want 0/1", wb_valid, in_ready); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h22 || rd !== 5'd3) $display("FAIL b2b_second: got %b/%h/%0d want 1/22/3", wb_valid, wb_data, rd); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      // resp_valid while idle is ignored
      dcache_resp_valid = 1'b1; dcache_dout = 32'h12345678;
      @(posedge clk); @(negedge clk);
      dcache_resp_valid = 1'b0;
      total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL idle_resp: got wb=%b rdy=%b want 0/1", wb_valid, in_ready); else pass_cnt++;
      // reset during REQ
      inst_in = 32'h00002483; alu_out = 32'h3000; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      total_cnt++; if (dcache_req_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_in_req: got req=%b rdy=%b want 0/1", dcache_req_valid, in_ready); else pass_cnt++;
      // move csr away from reset value, then reset during RESP
      rs1_to_csr = 32'h0000BEEF; inst_in = 32'h51E09073; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      inst_in = 32'h00002483; alu_out = 32'h3000; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; dcache_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      dcache_req_ready = 1'b0;
      total_cnt++; if (dcache_req_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL resp_wait: got req=%b wb=%b rdy=%b want 0/0/0", dcache_req_valid, wb_valid, in_ready); else pass_cnt++;
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      dcache_resp_valid = 1'b1; dcache_dout = 32'hAAAA5555;
      total_cnt++; if (in_ready !== 1'b1 || csr_out !== 32'h0) $display("FAIL reset_in_resp: got rdy=%b csr=%h want 1/0", in_ready, csr_out); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      dcache_resp_valid = 1'b0;
      total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL late_resp: got wb=%b rdy=%b want 0/1", wb_valid, in_ready); else pass_cnt++;
      @(posedge clk); @(negedge clk);
      total_cnt++; if (wb_valid !== 1'b0 || rd !== 5'd0) $display("FAIL late_resp2: got wb=%b rd=%0d want 0/0", wb_valid, rd); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; inst_in = '0; pc_in = '0; alu_out = '0;
      store_data = '0; rs1_to_csr = '0; dcache_req_ready = 1'b0;
      dcache_resp_valid = 1'b0; dcache_dout = '0;
      @(negedge clk);
      test_reset();
      test_alu_jump();
      test_load();
      test_store();
      test_misalign();
      test_csr();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/mem_wb_unit.md
# mem_wb_unit

Parametrised memory/writeback stage for the 3-stage RISC-V pipeline, sitting between the execute stage and the register file/CSR. It takes one instruction at a time under a valid/ready handshake and drives the data cache through a request/response handshake. Its byte-lane logic produces per-lane store enables and sign/zero-extended load data, and it maintains the tohost CSR (0x51E). It adds multi-cycle cache latency, true byte enables, misalignment detection and stall generation, none of which a purely combinational stage can provide.

## Interface
- XLEN, 32: datapath width; must be 32 or 64.
- CSR_RESET, 0: reset value of csr_out.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents an instruction.
- in_ready  output  1  unit can accept; high only in IDLE.
- inst_in  input  32  instruction word.
- pc_in  input  XLEN  instruction PC.
- alu_out  input  XLEN  ALU result, or effective address for load/store.
- store_data  input  XLEN  rs2 value for stores.
- rs1_to_csr  input  XLEN  rs1 value for csrw.
- dcache_req_valid  output  1  request to dcache.
- dcache_req_ready  input  1  dcache accepts the request.
- dcache_addr  output  XLEN  address with its low log2(XLEN/8) bits cleared.
- dcache_we  output  XLEN/8  byte-lane write enables; all 0 means read.
- dcache_din  output  XLEN  lane-aligned store data.
- dcache_resp_valid  input  1  load data valid.
- dcache_dout  input  XLEN  load data (full word).
- wb_valid  output  1  one-cycle pulse; wb_data/rd are valid.
- wb_data  output  XLEN  writeback value.
- rd  output  5  destination register; 0 when there is no writeback.
- csr_out  output  XLEN  tohost CSR value.
- misalign  output  1  one-cycle pulse on a misaligned load or store.

## Operation
- Decode uses the opcode.
  - LOAD 0000011 and STORE 0100011 are memory operations.
  - JAL 1101111 and JALR 1100111 write back pc_in+4.
  - SYSTEM 1110011 with inst[31:20]=0x51E: funct3 001 (csrw) writes rs1_to_csr; funct3 101 (csrwi) writes zero-extended inst[19:15].
  - OP, OP-IMM, LUI and AUIPC write back alu_out.
  - BRANCH, STORE and SYSTEM have no writeback: rd=0, and wb_valid still pulses to retire the instruction.
- Byte offset off = alu_out[log2(XLEN/8)-1:0].
- Alignment: B is always aligned; H needs off[0]=0; W needs off[1:0]=0; D (XLEN=64 only) needs off=0.
- Store lanes:
  - SB: we = 1<<off, din = byte replicated across all lanes.
  - SH: we = 2'b11<<off, din = half replicated.
  - SW: we = 4'hF<<off, din = word replicated.
  - SD: all lanes enabled.
- Load extract: the field at off is shifted to bit 0. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- Misaligned access: no dcache request is issued, misalign pulses, wb_valid pulses with rd=0, and no write occurs.
- Unknown opcode: retired as a no-writeback instruction.
- State machine:
  - IDLE: when in_valid, the instruction is latched. An aligned load/store goes to REQ; anything else goes to DONE.
  - REQ: dcache_req_valid=1 with stable addr/we/din until req_ready. Store → DONE. Load → RESP, or directly DONE if resp_valid is high in the same cycle.
  - RESP: wait for dcache_resp_valid, then capture the extracted data and go to DONE.
  - DONE: wb_valid=1 and the CSR update takes effect; next state is IDLE.
- dcache_resp_valid outside REQ/RESP is ignored.

## Timing
- Reset values:
  - state IDLE.
  - in_ready 1.
  - dcache_req_valid 0, dcache_we 0, dcache_addr 0, dcache_din 0.
  - wb_valid 0, wb_data 0, rd 0, misalign 0.
  - csr_out CSR_RESET.
- All outputs are registered except in_ready, which is decoded from state.
- Non-memory instruction: accepted in cycle N, wb_valid in N+1. Throughput is one instruction per 2 cycles.
- Store: accepted N, req_valid from N+1. If ready is in cycle M, wb_valid is in M+1.
- Load: accepted N, req_valid from N+1, handshake at M, resp_valid at R≥M, wb_valid at R+1. Minimum latency is 2 cycles.
- csr_out changes at the same edge that raises wb_valid.
- misalign pulses in the same cycle as its wb_valid.
- Reset mid-operation (REQ/RESP) aborts the instruction: req_valid drops the next cycle, there is no wb_valid, and a later resp_valid is ignored.
- in_valid while not in IDLE is not accepted, because in_ready=0.

## Test plan
- ADD: alu_out=0x1234 → wb_valid one cycle later, wb_data=0x1234, rd=inst[11:7].
- LB, addr 0x1003, dcache_dout=0x80FF_FF00, ready after 2 cycles, resp 3 cycles later → dcache_addr=0x1000, we=0, wb_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH, addr 0x2002, rs2=0xABCD_1234 → we=4'b1100, din=0x1234_1234; wb_valid with rd=0 the cycle after the request handshake.
- LW at 0x2001 → misalign pulse, no dcache_req_valid, rd=0.
- csrw 0x51E with rs1=0xDEAD_BEEF → csr_out=0xDEADBEEF. csrwi imm=5 → csr_out=5.
- Reset asserted while in RESP, then resp_valid arrives → no wb_valid, in_ready=1, csr_out=CSR_RESET.
